// File: rtl/shift_word_driver.sv
// Streams an N-bit word into a bi_directional shift register through its serial inputs and reassembles
// the bits it shifts out; m_valid follows the accept edge by N+1 cycles and waits in DONE for m_ready.
module shift_word_driver #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic         s_dir,
  input  logic [N-1:0] s_data,
  output logic         sr_mode,
  output logic         sr_r_serialin,
  output logic         sr_l_serialin,
  input  logic         sr_out,
  output logic         sr_loaded,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [N-1:0] m_data
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CAPTURE, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic [N-1:0]  word_q, word_d;
  logic [N-1:0]  rx_q, rx_d;
  logic          cap_en;
  logic [CW-1:0] cap_idx;
  logic          tx_bit;

  // sr_out is registered inside the shift register, so the bit leaving at the edge ending cnt=k is
  // seen one edge later; in CAPTURE cnt has reached N, giving the final index N-1.
  assign cap_en  = ((state_q == SHIFT) && (cnt_q != '0)) || (state_q == CAPTURE);
  assign cap_idx = cnt_q - CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      word_q  <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      word_q  <= word_d;
      rx_q    <= rx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    word_d  = word_q;
    rx_d    = rx_q;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          state_d = SHIFT;
          cnt_d   = '0;
          dir_d   = s_dir;
          word_d  = s_data;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: state_d = DONE;
      DONE: begin
        if (m_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Right shifts deliver the old contents LSB first, left shifts MSB first.
    for (int i = 0; i < N; i++) begin
      if (cap_en && ((dir_q && (cap_idx == CW'(i))) || (!dir_q && (cap_idx == CW'(N - 1 - i))))) begin
        rx_d[i] = sr_out;
      end
    end
  end

  always_comb begin
    tx_bit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (dir_q ? (cnt_q == CW'(i)) : (cnt_q == CW'(N - 1 - i))) begin
        tx_bit = word_q[i];
      end
    end
    s_ready       = (state_q == IDLE);
    sr_mode       = dir_q;
    sr_r_serialin = (state_q == SHIFT) && dir_q && tx_bit;
    sr_l_serialin = (state_q == SHIFT) && !dir_q && tx_bit;
    sr_loaded     = (state_q == CAPTURE);
    m_valid       = (state_q == DONE);
    m_data        = rx_q;
  end

endmodule

// File: tb/tb_shift_word_driver.sv
// Bench for shift_word_driver with a behavioural bi_directional register attached to its serial side.
module tb_shift_word_driver;
  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic         s_valid;
  logic         s_ready;
  logic         s_dir;
  logic [N-1:0] s_data;
  logic         sr_mode;
  logic         sr_r_serialin;
  logic         sr_l_serialin;
  logic         sr_out;
  logic         sr_loaded;
  logic         m_valid;
  logic         m_ready;
  logic [N-1:0] m_data;
  logic [N-1:0] sr_q;

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;
  int n_load = 0;
  int n_ret  = 0;
  logic [N-1:0] exp_load[$];
  logic [N-1:0] exp_m[$];
  logic [N-1:0] mon_e;
  bit           pend = 1'b0;

  shift_word_driver #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_dir(s_dir), .s_data(s_data),
    .sr_mode(sr_mode), .sr_r_serialin(sr_r_serialin), .sr_l_serialin(sr_l_serialin),
    .sr_out(sr_out), .sr_loaded(sr_loaded),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference bi_directional: shifts every clock, out is the registered shifted-out bit.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      sr_out <= 1'b0;
    end else if (sr_mode) begin
      sr_q   <= {sr_r_serialin, sr_q[N-1:1]};
      sr_out <= sr_q[0];
    end else begin
      sr_q   <= {sr_q[N-2:0], sr_l_serialin};
      sr_out <= sr_q[N-1];
    end
  end

  // Scoreboard: loaded word expected at sr_loaded, returned word is the register contents seen in
  // the first SHIFT cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_load.delete();
      exp_m.delete();
      pend = 1'b0;
    end else begin
      if (pend) begin
        exp_m.push_back(sr_q);
        pend = 1'b0;
      end
      if (s_valid && s_ready) begin
        exp_load.push_back(s_data);
        pend = 1'b1;
        n_acc++;
      end
      if (sr_loaded) begin
        checks++;
        n_load++;
        if (exp_load.size() == 0) begin
          errors++;
          $display("FAIL sb_loaded unexpected sr_loaded, q=%b", sr_q);
        end else begin
          mon_e = exp_load.pop_front();
          if (sr_q !== mon_e) begin
            errors++;
            $display("FAIL sb_loaded q=%b expected %b", sr_q, mon_e);
          end
        end
      end
      if (m_valid && m_ready) begin
        checks++;
        n_ret++;
        if (exp_m.size() == 0) begin
          errors++;
          $display("FAIL sb_mdata unexpected word m_data=%b", m_data);
        end else begin
          mon_e = exp_m.pop_front();
          if (m_data !== mon_e) begin
            errors++;
            $display("FAIL sb_mdata m_data=%b expected %b", m_data, mon_e);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b1;
    s_valid = 1'b0; s_dir = 1'b0; s_data = '0; m_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_ready, sr_mode, sr_r_serialin, sr_l_serialin, sr_loaded, m_valid} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl got %b expected 100000",
               {s_ready, sr_mode, sr_r_serialin, sr_l_serialin, sr_loaded, m_valid});
    end
    checks++;
    if (m_data !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mdata got %b expected 0000", m_data);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_word(input logic [N-1:0] d, input logic dir, input logic [N-1:0] exp_r,
                          input logic [N-1:0] exp_l, input logic [N-1:0] exp_md, input string nm);
    logic [N-1:0] r_seq;
    logic [N-1:0] l_seq;
    @(posedge clk);
    #1 s_data = d; s_dir = dir; s_valid = 1'b1; m_ready = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      r_seq[k] = sr_r_serialin;
      l_seq[k] = sr_l_serialin;
    end
    checks++;
    if (r_seq !== exp_r || l_seq !== exp_l) begin
      errors++;
      $display("FAIL %s_serial r=%b l=%b expected r=%b l=%b", nm, r_seq, l_seq, exp_r, exp_l);
    end
    @(negedge clk);
    checks++;
    if ({sr_loaded, m_valid} !== 2'b10 || sr_q !== d) begin
      errors++;
      $display("FAIL %s_loaded loaded=%b m_valid=%b q=%b expected 1 0 %b", nm, sr_loaded, m_valid, sr_q, d);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== exp_md) begin
      errors++;
      $display("FAIL %s_return m_valid=%b m_data=%b expected 1 %b", nm, m_valid, m_data, exp_md);
    end
  endtask

  task automatic test_right_load();
    run_word(4'b1011, 1'b1, 4'b1011, 4'b0000, 4'b0000, "right");
  endtask

  // Filler shifts after 1011 leave 0001 in the register when 0110 starts shifting in.
  task automatic test_left_exchange();
    run_word(4'b0110, 1'b0, 4'b0000, 4'b0110, 4'b0001, "left");
  endtask

  task automatic test_backpressure();
    logic [N-1:0] exp_now;
    bit got;
    @(posedge clk);
    #1 s_data = 4'b1100; s_dir = 1'b1; s_valid = 1'b1; m_ready = 1'b0;
    @(posedge clk);
    #1 s_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = m_valid;
    end
    checks++;
    if (!got || exp_m.size() != 1) begin
      errors++;
      $display("FAIL bp_wait m_valid=%b queued=%0d expected 1 1", m_valid, exp_m.size());
      exp_now = 'x;
    end else begin
      exp_now = exp_m[0];
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 s_valid = i[0]; s_data = N'($urandom); s_dir = 1'($urandom);
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || s_ready !== 1'b0 || m_data !== exp_now) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d m_valid=%b s_ready=%b m_data=%b expected 1 0 %b",
                 i, m_valid, s_ready, m_data, exp_now);
      end
    end
    @(posedge clk);
    #1 m_ready = 1'b1; s_valid = 1'b1; s_data = 4'b0011; s_dir = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_idle s_ready=%b m_valid=%b expected 1 0", s_ready, m_valid);
    end
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept s_ready=%b expected 0", s_ready);
    end
    @(posedge clk);
    #1 s_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = s_ready && (exp_m.size() == 0);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL bp_drain s_ready=%b queued=%0d expected 1 0", s_ready, exp_m.size());
    end
  endtask

  task automatic test_reset_mid_shift();
    int ld0;
    int rt0;
    @(posedge clk);
    #1 s_data = 4'b0100; s_dir = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (sr_r_serialin !== 1'b1 || sr_mode !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre r_serialin=%b mode=%b expected 1 1", sr_r_serialin, sr_mode);
    end
    ld0 = n_load;
    rt0 = n_ret;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({s_ready, sr_mode, sr_r_serialin, sr_l_serialin, sr_loaded, m_valid} !== 6'b100000 ||
        m_data !== 4'b0000) begin
      errors++;
      $display("FAIL abort_outputs ctrl=%b m_data=%b expected 100000 0000",
               {s_ready, sr_mode, sr_r_serialin, sr_l_serialin, sr_loaded, m_valid}, m_data);
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (n_load != ld0 || n_ret != rt0) begin
      errors++;
      $display("FAIL abort_silent loaded=%0d returned=%0d expected 0 0", n_load - ld0, n_ret - rt0);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] w[3];
    logic         d[3];
    int           acc[3];
    int           n;
    int           cyc;
    bit           took;
    bit           got;
    w[0] = 4'b1001; w[1] = 4'b0111; w[2] = 4'b1110;
    d[0] = 1'b1;    d[1] = 1'b0;    d[2] = 1'b1;
    n = 0;
    cyc = 0;
    @(posedge clk);
    #1 s_valid = 1'b1; s_data = w[0]; s_dir = d[0]; m_ready = 1'b1;
    for (int it = 0; it < 60 && n < 3; it++) begin
      @(negedge clk);
      took = s_ready;
      if (took) begin
        acc[n] = cyc;
        n++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (took) begin
        if (n < 3) begin
          s_data = w[n];
          s_dir  = d[n];
        end else begin
          s_valid = 1'b0;
        end
      end
    end
    s_valid = 1'b0;
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL b2b_count accepted=%0d expected 3", n);
    end else begin
      checks++;
      if (acc[1] - acc[0] != N + 3 || acc[2] - acc[1] != N + 3) begin
        errors++;
        $display("FAIL b2b_spacing gaps=%0d,%0d expected %0d", acc[1] - acc[0], acc[2] - acc[1], N + 3);
      end
    end
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = s_ready && (exp_m.size() == 0);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL b2b_drain s_ready=%b queued=%0d expected 1 0", s_ready, exp_m.size());
    end
  endtask

  task automatic test_random();
    int a0;
    int l0;
    int r0;
    int guard;
    bit got;
    a0 = n_acc;
    l0 = n_load;
    r0 = n_ret;
    guard = 0;
    while (n_acc - a0 < 200 && guard < 20000) begin
      @(posedge clk);
      #1;
      s_valid = ($urandom_range(0, 2) != 0);
      s_data  = N'($urandom);
      s_dir   = 1'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      guard++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = s_ready && (exp_m.size() == 0) && (exp_load.size() == 0);
    end
    checks++;
    if (!got || n_acc - a0 != 200 || n_load - l0 != 200 || n_ret - r0 != 200) begin
      errors++;
      $display("FAIL rand_totals accepted=%0d loaded=%0d returned=%0d drained=%b expected 200 200 200 1",
               n_acc - a0, n_load - l0, n_ret - r0, got);
    end
  endtask

  initial begin
    test_reset();
    test_right_load();
    test_left_exchange();
    test_backpressure();
    test_reset_mid_shift();
    test_right_load();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
